// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- VGA raster timing generator with a divided pixel tick.
//
// A clk divider produces a one-clk pixel tick (pix_en). Each tick advances
// the horizontal counter, and the vertical counter advances when the
// horizontal counter wraps. Sync pulses and blanked colour are registered
// on the tick, so hsync/vsync/rgb are mutually aligned and lag hpos/vpos by
// one pixel tick.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-high reset
//   rgb_in[2:0]  in   {R,G,B} colour for the pixel at the current hpos/vpos
//   pix_en       out  one-clk pixel tick strobe
//   hpos[9:0]    out  horizontal pixel counter, 0..H_TOTAL-1
//   vpos[9:0]    out  vertical line counter, 0..V_TOTAL-1
//   display_on   out  current hpos/vpos lies in the visible area (combinational)
//   hsync        out  registered horizontal sync, active level SYNC_POL
//   vsync        out  registered vertical sync, active level SYNC_POL
//   rgb[2:0]     out  registered colour, forced to 0 outside the visible area
//   frame_start  out  one-clk pulse on the tick at hpos=0, vpos=0
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic       pix_en,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic       frame_start
);

  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS    = 10'(H_DISP);
  localparam logic [9:0]    V_VIS    = 10'(V_DISP);
  localparam logic [9:0]    HS_FIRST = 10'(H_DISP + H_FP);
  localparam logic [9:0]    HS_LAST  = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0]    VS_FIRST = 10'(V_DISP + V_FP);
  localparam logic [9:0]    VS_LAST  = 10'(V_DISP + V_FP + V_SYNC - 1);
  localparam logic          SYNC_ACT = (SYNC_POL != 0);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    hpos_q, hpos_d;
  logic [9:0]    vpos_q, vpos_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          tick, h_wrap, v_wrap, disp, hs_act, vs_act;

  always_comb begin
    tick   = (div_q == DIV_MAX);
    h_wrap = (hpos_q == H_MAX);
    v_wrap = (vpos_q == V_MAX);
    disp   = (hpos_q < H_VIS) && (vpos_q < V_VIS);
    hs_act = (hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST);
    vs_act = (vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST);

    div_d   = tick ? '0 : div_q + 1'b1;
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;

    if (tick) begin
      hpos_d  = h_wrap ? '0 : hpos_q + 10'd1;
      if (h_wrap) begin
        vpos_d = v_wrap ? '0 : vpos_q + 10'd1;
      end
      hsync_d = hs_act ? SYNC_ACT : ~SYNC_ACT;
      vsync_d = vs_act ? SYNC_ACT : ~SYNC_ACT;
      rgb_d   = disp ? rgb_in : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      hpos_q  <= '0;
      vpos_q  <= '0;
      hsync_q <= ~SYNC_ACT;
      vsync_q <= ~SYNC_ACT;
      rgb_q   <= '0;
    end else begin
      div_q   <= div_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  // The tick is decoded from the divider, so it is masked with reset to keep
  // pix_en low during reset even when CLK_DIV=1 (divider always at its max).
  // This also makes the first tick cover the CLK_DIV-th clk after release.
  assign pix_en      = tick & ~reset;
  assign frame_start = pix_en & (hpos_q == '0) & (vpos_q == '0);
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign display_on  = disp;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

  // Small raster so whole frames fit in a short run.
  localparam int unsigned HD = 10, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VD = 6,  VF = 1, VS = 2, VB = 2;
  localparam int unsigned HT = HD + HF + HS + HB;   // 17
  localparam int unsigned VT = VD + VF + VS + VB;   // 11
  localparam int unsigned DA = 3;                   // instance A: CLK_DIV=3, active-low sync
  localparam int unsigned DB = 1;                   // instance B: CLK_DIV=1, active-high sync

  logic       clk, reset;
  logic [2:0] rgbi_a, rgbi_b;
  logic       pe_a, disp_a, hs_a, vs_a, fs_a;
  logic       pe_b, disp_b, hs_b, vs_b, fs_b;
  logic [9:0] hp_a, vp_a, hp_b, vp_b;
  logic [2:0] rgbo_a, rgbo_b;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  vga_sync_gen #(.CLK_DIV(DA), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)) dut_a (
    .clk(clk), .reset(reset), .rgb_in(rgbi_a), .pix_en(pe_a), .hpos(hp_a), .vpos(vp_a),
    .display_on(disp_a), .hsync(hs_a), .vsync(vs_a), .rgb(rgbo_a), .frame_start(fs_a));

  vga_sync_gen #(.CLK_DIV(DB), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1)) dut_b (
    .clk(clk), .reset(reset), .rgb_in(rgbi_b), .pix_en(pe_b), .hpos(hp_b), .vpos(vp_b),
    .display_on(disp_b), .hsync(hs_b), .vsync(vs_b), .rgb(rgbo_b), .frame_start(fs_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Time is counted in clk edges since reset release; the pixel index is
  // edges/CLK_DIV, and raster position follows from division by the totals.
  int unsigned ea, eb;
  logic        mhs_a, mvs_a, mhs_b, mvs_b;
  logic [2:0]  mrgb_a, mrgb_b;

  function automatic logic in_hsync(int unsigned h);
    return (h >= HD + HF) && (h < HD + HF + HS);
  endfunction

  function automatic logic in_vsync(int unsigned v);
    return (v >= VD + VF) && (v < VD + VF + VS);
  endfunction

  function automatic logic in_vis(int unsigned n);
    return ((n % HT) < HD) && (((n / HT) % VT) < VD);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ea <= 0; mhs_a <= 1'b1; mvs_a <= 1'b1; mrgb_a <= 3'b000;
      eb <= 0; mhs_b <= 1'b0; mvs_b <= 1'b0; mrgb_b <= 3'b000;
    end else begin
      if (ea % DA == DA - 1) begin
        mhs_a  <= ~in_hsync((ea / DA) % HT);
        mvs_a  <= ~in_vsync(((ea / DA) / HT) % VT);
        mrgb_a <= in_vis(ea / DA) ? rgbi_a : 3'b000;
      end
      if (eb % DB == DB - 1) begin
        mhs_b  <= in_hsync((eb / DB) % HT);
        mvs_b  <= in_vsync(((eb / DB) / HT) % VT);
        mrgb_b <= in_vis(eb / DB) ? rgbi_b : 3'b000;
      end
      ea <= ea + 1;
      eb <= eb + 1;
    end
  end

  // {pix_en, hpos, vpos, display_on, hsync, vsync, rgb, frame_start}
  function automatic logic [27:0] expect_vec(int unsigned e, int unsigned d, logic rst,
                                             logic hs, logic vs, logic [2:0] r);
    int unsigned n, h, v;
    logic pe;
    n  = e / d;
    h  = n % HT;
    v  = (n / HT) % VT;
    pe = !rst && (e % d == d - 1);
    return {pe, 10'(h), 10'(v), (h < HD) && (v < VD), hs, vs, r, pe && (h == 0) && (v == 0)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; rgbi_a = 3'b000; rgbi_b = 3'b000;
    #1;
    for (int unsigned i = 0; i < 2; i++) begin
      n_chk++;
      if ({pe_a, hp_a, vp_a, hs_a, vs_a, rgbo_a, fs_a} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 3'b000, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_a: got pe=%b h=%0d v=%0d hs=%b vs=%b rgb=%b fs=%b, want 0 0 0 1 1 000 0",
                 pe_a, hp_a, vp_a, hs_a, vs_a, rgbo_a, fs_a);
      end
      n_chk++;
      if ({pe_b, hp_b, vp_b, hs_b, vs_b, rgbo_b, fs_b} !== {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 3'b000, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_b: got pe=%b h=%0d v=%0d hs=%b vs=%b rgb=%b fs=%b, want 0 0 0 0 0 000 0",
                 pe_b, hp_b, vp_b, hs_b, vs_b, rgbo_b, fs_b);
      end
      repeat (7) @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  // Called right after reset falls on a negedge; k = clk edges seen since release.
  task automatic test_first_tick(string tag);
    #1;
    for (int unsigned k = 0; k <= DA + 1; k++) begin
      n_chk++;
      if ({pe_a, fs_a, hp_a, vp_a} !== {k == DA - 1, k == DA - 1, (k >= DA) ? 10'd1 : 10'd0, 10'd0}) begin
        n_fail++;
        $display("FAIL %s_a k=%0d: got pe=%b fs=%b h=%0d v=%0d, want pe=%b fs=%b h=%0d v=0",
                 tag, k, pe_a, fs_a, hp_a, vp_a, k == DA - 1, k == DA - 1, (k >= DA) ? 1 : 0);
      end
      n_chk++;
      if ({pe_b, fs_b, hp_b, vp_b} !== {1'b1, k == 0, 10'(k), 10'd0}) begin
        n_fail++;
        $display("FAIL %s_b k=%0d: got pe=%b fs=%b h=%0d v=%0d, want pe=1 fs=%b h=%0d v=0",
                 tag, k, pe_b, fs_b, hp_b, vp_b, k == 0, k);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random(int unsigned ncyc);
    logic [27:0] exp_v, obs_v;
    for (int unsigned c = 0; c < ncyc; c++) begin
      @(negedge clk);
      exp_v = expect_vec(ea, DA, reset, mhs_a, mvs_a, mrgb_a);
      obs_v = {pe_a, hp_a, vp_a, disp_a, hs_a, vs_a, rgbo_a, fs_a};
      n_chk++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL random_a cyc=%0d: got %h want %h", c, obs_v, exp_v);
      end
      exp_v = expect_vec(eb, DB, reset, mhs_b, mvs_b, mrgb_b);
      obs_v = {pe_b, hp_b, vp_b, disp_b, hs_b, vs_b, rgbo_b, fs_b};
      n_chk++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL random_b cyc=%0d: got %h want %h", c, obs_v, exp_v);
      end
      rgbi_a = 3'($urandom);
      rgbi_b = 3'($urandom);
    end
  endtask

  task automatic test_hsync_width();
    logic prev;
    int   run, last_fall, falls;
    run = 0; last_fall = -1; falls = 0;
    @(negedge clk);
    prev = hs_a;
    for (int c = 0; c < int'(4 * HT * DA); c++) begin
      @(negedge clk);
      if (prev && !hs_a) begin
        n_chk++;
        if (hp_a !== 10'(HD + HF + 1)) begin
          n_fail++;
          $display("FAIL hsync_start: hpos at first low clk %0d, want %0d", hp_a, HD + HF + 1);
        end
        if (last_fall >= 0) begin
          n_chk++;
          if (c - last_fall != int'(HT * DA)) begin
            n_fail++;
            $display("FAIL line_period: %0d clk, want %0d", c - last_fall, HT * DA);
          end
        end
        last_fall = c; run = 0; falls++;
      end
      if (!hs_a) run++;
      if (!prev && hs_a && falls > 0) begin
        n_chk++;
        if (run != int'(HS * DA)) begin
          n_fail++;
          $display("FAIL hsync_width: %0d clk, want %0d", run, HS * DA);
        end
      end
      prev = hs_a;
    end
    n_chk++;
    if (falls < 3) begin
      n_fail++;
      $display("FAIL hsync_seen: %0d pulses, want >= 3", falls);
    end
  endtask

  task automatic test_frame();
    logic prev;
    int   run, falls, last_fs, lit, windows;
    rgbi_a = 3'b111;
    run = 0; falls = 0; last_fs = -1; lit = 0; windows = 0;
    @(negedge clk);
    prev = vs_a;
    for (int c = 0; c < int'(3 * VT * HT * DA + 20); c++) begin
      @(negedge clk);
      if (fs_a) begin
        if (last_fs >= 0) begin
          n_chk++;
          if (c - last_fs != int'(VT * HT * DA)) begin
            n_fail++;
            $display("FAIL frame_period: %0d clk, want %0d", c - last_fs, VT * HT * DA);
          end
          n_chk++;
          if (lit != int'(HD * VD * DA)) begin
            n_fail++;
            $display("FAIL lit_clks: %0d, want %0d", lit, HD * VD * DA);
          end
          windows++;
        end
        last_fs = c; lit = 0;
      end
      if (rgbo_a == 3'b111) lit++;
      if (prev && !vs_a) begin run = 0; falls++; end
      if (!vs_a) run++;
      if (!prev && vs_a && falls > 0) begin
        n_chk++;
        if (run != int'(VS * HT * DA)) begin
          n_fail++;
          $display("FAIL vsync_width: %0d clk, want %0d", run, VS * HT * DA);
        end
      end
      prev = vs_a;
    end
    n_chk++;
    if (windows < 2 || falls < 2) begin
      n_fail++;
      $display("FAIL frame_seen: %0d frames %0d vsyncs, want >= 2 each", windows, falls);
    end
  endtask

  task automatic test_clkdiv1();
    logic phs, pvs;
    int   hrun, vrun, hrise, vrise, last_fs, nfs;
    rgbi_b = 3'b111;
    hrun = 0; vrun = 0; hrise = 0; vrise = 0; last_fs = -1; nfs = 0;
    @(negedge clk);
    phs = hs_b; pvs = vs_b;
    for (int c = 0; c < int'(2 * VT * HT + 10); c++) begin
      @(negedge clk);
      n_chk++;
      if (pe_b !== 1'b1) begin
        n_fail++;
        $display("FAIL div1_pix_en cyc=%0d: got %b want 1", c, pe_b);
      end
      if (fs_b) begin
        if (last_fs >= 0) begin
          n_chk++;
          if (c - last_fs != int'(VT * HT)) begin
            n_fail++;
            $display("FAIL div1_frame_period: %0d clk, want %0d", c - last_fs, VT * HT);
          end
        end
        last_fs = c; nfs++;
      end
      if (!phs && hs_b) begin hrun = 0; hrise++; end
      if (hs_b) hrun++;
      if (phs && !hs_b && hrise > 0) begin
        n_chk++;
        if (hrun != int'(HS)) begin
          n_fail++;
          $display("FAIL div1_hsync_width: %0d clk, want %0d", hrun, HS);
        end
      end
      if (!pvs && vs_b) begin vrun = 0; vrise++; end
      if (vs_b) vrun++;
      if (pvs && !vs_b && vrise > 0) begin
        n_chk++;
        if (vrun != int'(VS * HT)) begin
          n_fail++;
          $display("FAIL div1_vsync_width: %0d clk, want %0d", vrun, VS * HT);
        end
      end
      phs = hs_b; pvs = vs_b;
    end
    n_chk++;
    if (nfs < 2 || vrise < 1) begin
      n_fail++;
      $display("FAIL div1_seen: %0d frame starts %0d vsyncs", nfs, vrise);
    end
  endtask

  task automatic test_async_reset();
    int waited;
    waited = 0;
    rgbi_a = 3'b101;
    @(negedge clk);
    while (!(hp_a == 10'd5 && vp_a == 10'd3) && waited < int'(2 * VT * HT * DA)) begin
      @(negedge clk);
      waited++;
    end
    n_chk++;
    if (!(hp_a == 10'd5 && vp_a == 10'd3)) begin
      n_fail++;
      $display("FAIL mid_frame_reach: stuck at h=%0d v=%0d, want h=5 v=3", hp_a, vp_a);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({pe_a, hp_a, vp_a, hs_a, vs_a, rgbo_a, fs_a} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_a: got pe=%b h=%0d v=%0d hs=%b vs=%b rgb=%b fs=%b, want 0 0 0 1 1 000 0",
               pe_a, hp_a, vp_a, hs_a, vs_a, rgbo_a, fs_a);
    end
    n_chk++;
    if ({pe_b, hp_b, vp_b, hs_b, vs_b, rgbo_b, fs_b} !== {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_b: got pe=%b h=%0d v=%0d hs=%b vs=%b rgb=%b fs=%b, want 0 0 0 0 0 000 0",
               pe_b, hp_b, vp_b, hs_b, vs_b, rgbo_b, fs_b);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_first_tick("restart");
  endtask

  initial begin
    test_reset();
    test_first_tick("first_tick");
    test_random(700);
    test_hsync_width();
    test_frame();
    test_clkdiv1();
    test_async_reset();
    test_random(300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
